// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right Montgomery modular exponentiation sequencer
// Drives an external Montgomery multiplier; all outputs are registered.
module mont_exp_ctrl #(
  parameter int WIDTH = 256,
  parameter int EXP_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] M_bar,
  input  logic [WIDTH-1:0] One_bar,
  input  logic [EXP_W-1:0] E,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_n,
  output logic             mul_start,
  input  logic [WIDTH-1:0] mul_out,
  input  logic             mul_done,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    IDLE, SQ_ISSUE, SQ_WAIT, ML_ISSUE, ML_WAIT, CV_ISSUE, CV_WAIT, FIN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] m_bar_q, acc_q, out_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q, mul_n_q;
  logic [EXP_W-1:0] e_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q, done_q, mul_start_q;
  logic             e_bit;

  assign e_bit = e_q[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_bar_q     <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_n_q     <= '0;
      e_q         <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            m_bar_q     <= M_bar;
            e_q         <= E;
            mul_n_q     <= N;
            acc_q       <= One_bar;
            idx_q       <= IW'(EXP_W - 1);
            mul_a_q     <= One_bar;
            mul_b_q     <= One_bar;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SQ_ISSUE;
          end
        end
        SQ_ISSUE: state_q <= SQ_WAIT;
        ML_ISSUE: state_q <= ML_WAIT;
        CV_ISSUE: state_q <= CV_WAIT;
        // Operands for the next multiply are taken straight from mul_out,
        // since acc only holds that value from the following cycle on.
        SQ_WAIT, ML_WAIT: begin
          if (mul_done) begin
            acc_q       <= mul_out;
            mul_a_q     <= mul_out;
            mul_start_q <= 1'b1;
            if (state_q == SQ_WAIT && e_bit) begin
              mul_b_q <= m_bar_q;
              state_q <= ML_ISSUE;
            end else if (idx_q == '0) begin
              mul_b_q <= WIDTH'(1);
              state_q <= CV_ISSUE;
            end else begin
              mul_b_q <= mul_out;
              idx_q   <= idx_q - IW'(1);
              state_q <= SQ_ISSUE;
            end
          end
        end
        CV_WAIT: begin
          if (mul_done) begin
            acc_q   <= mul_out;
            out_q   <= mul_out;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_n     = mul_n_q;
  assign mul_start = mul_start_q;
  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - self-checking bench for mont_exp_ctrl with a 3-cycle multiplier model
module tb_mont_exp_ctrl;
  localparam int W  = 256;
  localparam int EW = 256;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  M_bar, One_bar, N, mul_a, mul_b, mul_n, mul_out, out;
  logic [EW-1:0] E;
  logic          mul_start, mul_done, busy, done;

  logic [W-1:0]  model_out = '0, junk = '0, pend_res = '0, cap_a = '0, cap_b = '0;
  logic          model_done = 1'b0, inj_done = 1'b0;
  int            lat = 0;
  int            stable_err = 0, pulses = 0, dones = 0, both_err = 0;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign mul_done = model_done | inj_done;
  assign mul_out  = inj_done ? junk : model_out;

  mont_exp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .M_bar(M_bar), .One_bar(One_bar),
    .E(E), .N(N), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
    .mul_start(mul_start), .mul_out(mul_out), .mul_done(mul_done),
    .out(out), .busy(busy), .done(done)
  );

  // a*b*2^-W mod n, by halving modulo an odd n W times
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
    longint unsigned x, nn;
    nn = n[63:0];
    if (nn == 0) return '0;
    x = ((a[63:0] % nn) * (b[63:0] % nn)) % nn;
    for (int i = 0; i < W; i++) x = x[0] ? (x + nn) >> 1 : x >> 1;
    return W'(x);
  endfunction

  function automatic longint unsigned r_mod(input longint unsigned n);
    longint unsigned r = 1 % n;
    for (int i = 0; i < W; i++) r = (r * 2) % n;
    return r;
  endfunction

  function automatic longint unsigned pow_ref(input longint unsigned m, input logic [EW-1:0] e,
                                              input longint unsigned n);
    longint unsigned r = 1 % n;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * (m % n)) % n;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    model_done = 1'b0;
    if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        model_done = 1'b1;
        model_out  = pend_res;
        if (busy === 1'b1 && (mul_a !== cap_a || mul_b !== cap_b)) stable_err++;
      end
    end
    if (mul_start === 1'b1) begin
      lat      = 3;
      pend_res = mont_ref(mul_a, mul_b, mul_n);
      cap_a    = mul_a;
      cap_b    = mul_b;
    end
  end

  always @(negedge clk) begin
    if (mul_start === 1'b1) pulses++;
    if (done === 1'b1) dones++;
    if (done === 1'b1 && busy === 1'b1) both_err++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    M_bar   = rnd256();
    One_bar = rnd256();
    E       = rnd256();
    N       = rnd256();
  endtask

  task automatic run_op(input string nm, input longint unsigned m, input logic [EW-1:0] e,
                        input longint unsigned n, input int exp_pulses,
                        input longint unsigned exp_out, input int restart_at, input int inj_at);
    int p0, d0, s0, cyc;
    bit restarted;
    longint unsigned rm;
    rm = r_mod(n);
    M_bar   = W'(((m % n) * rm) % n);
    One_bar = W'(rm);
    E       = e;
    N       = W'(n);
    p0 = pulses; d0 = dones; s0 = stable_err; cyc = 0; restarted = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, " busy_after_start"}, W'(busy), W'(1));
    scramble();
    while (done !== 1'b1 && cyc < 20000) begin
      start    = 1'b0;
      inj_done = 1'b0;
      if (restart_at > 0 && !restarted && pulses - p0 == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (inj_at > 0 && mul_start === 1'b1 && pulses - p0 == inj_at) begin
        junk     = rnd256();
        inj_done = 1'b1;
      end
      scramble();
      tick();
      cyc++;
    end
    start    = 1'b0;
    inj_done = 1'b0;
    chk({nm, " done_seen"}, W'(done === 1'b1), W'(1));
    chk({nm, " out"}, out, W'(exp_out));
    chk({nm, " busy_in_fin"}, W'(busy), W'(0));
    repeat (4) tick();
    chk({nm, " mul_start_pulses"}, W'(pulses - p0), W'(exp_pulses));
    chk({nm, " done_pulses"}, W'(dones - d0), W'(1));
    chk({nm, " operands_stable"}, W'(stable_err - s0), W'(0));
    chk({nm, " out_held"}, out, W'(exp_out));
  endtask

  typedef struct {
    string           nm;
    longint unsigned m;
    logic [EW-1:0]   e;
    longint unsigned n;
    int              pulses;
    longint unsigned res;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   d0, cyc;
    logic [W-1:0] prev_out;

    tbl[0] = '{"e0_m3_n7",    3,  256'd0,   7,  257, 1};
    tbl[1] = '{"e3_m2_n13",   2,  256'd3,   13, 259, 8};
    tbl[2] = '{"e1_m5_n7",    5,  256'd1,   7,  258, 5};
    tbl[3] = '{"e13_m4_n11",  4,  256'd13,  11, 260, 9};
    tbl[4] = '{"e255_m10_n17", 10, 256'd255, 17, 265, 12};

    rst = 1'b1; start = 1'b0; inj_done = 1'b0;
    M_bar = '0; One_bar = '0; E = '0; N = '0;
    repeat (3) tick();
    chk("rst out", out, '0);
    chk("rst busy", W'(busy), '0);
    chk("rst done", W'(done), '0);
    chk("rst mul_start", W'(mul_start), '0);
    chk("rst mul_a", mul_a, '0);
    chk("rst mul_b", mul_b, '0);
    chk("rst mul_n", mul_n, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_op(tbl[i].nm, tbl[i].m, tbl[i].e, tbl[i].n, tbl[i].pulses, tbl[i].res, 0, 0);

    run_op("restart_ignored", tbl[1].m, tbl[1].e, tbl[1].n, tbl[1].pulses, tbl[1].res, 100, 0);

    // Reset during the first SQ_WAIT; the in-flight multiply completes afterwards.
    M_bar = W'(((2 % 13) * r_mod(13)) % 13); One_bar = W'(r_mod(13)); E = 256'd3; N = 256'd13;
    d0 = dones;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (mul_start !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("midrst issue_seen", W'(mul_start === 1'b1), W'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst out", out, '0);
    chk("midrst busy", W'(busy), '0);
    chk("midrst mul_start", W'(mul_start), '0);
    chk("midrst mul_a", mul_a, '0);
    chk("midrst mul_b", mul_b, '0);
    chk("midrst mul_n", mul_n, '0);
    chk("midrst no_done", W'(dones - d0), '0);
    run_op("after_rst", 2, 256'd3, 13, 259, 8, 0, 0);

    // Stray mul_done while idle, then during an ISSUE cycle.
    prev_out = out;
    junk = rnd256();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    chk("idle_done out", out, prev_out);
    chk("idle_done busy", W'(busy), '0);
    run_op("issue_done", 5, 256'd1, 7, 258, 5, 0, 50);

    for (int r = 0; r < 5; r++) begin
      longint unsigned n, m;
      logic [EW-1:0] e;
      n = longint'($urandom_range(32'h000F_FFFF, 32'h0008_0000)) | 1;
      m = longint'($urandom) % n;
      e = (r == 0) ? '1 : rnd256();
      run_op($sformatf("rand%0d", r), m, e, n, EW + $countones(e) + 1, pow_ref(m, e, n), 0, 0);
    end

    chk("done_busy_exclusive", W'(both_err), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
